// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu -- registered arithmetic/logic unit with status flags.
//
// Computes ADD, SUB, AND, OR, XOR or an unsigned less-than on two WIDTH-bit
// operands each cycle. The result and flags appear one clock after the
// operands are sampled. No input reaches an output combinationally.
//
// Ports
//   clk        in   1                rising-edge clock
//   reset      in   1                asynchronous, active-high reset
//   op1        in   WIDTH            operand A
//   op2        in   WIDTH            operand B
//   operation  in   alu_operation_t  operation select
//   result     out  WIDTH            registered result
//   zero       out  1                result is all zeros
//   carry      out  1                ADD carry-out / SUB borrow (A < B)
//   overflow   out  1                signed overflow of ADD/SUB
//   negative   out  1                result MSB
// ----------------------------------------------------------------------------

package custom_types;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_LT  = 3'd5
    } alu_operation_t;

endpackage

module alu
    import custom_types::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    input  alu_operation_t       operation,
    output logic [WIDTH-1:0]     result,
    output logic                 zero,
    output logic                 carry,
    output logic                 overflow,
    output logic                 negative
);

    // One extra bit holds the ADD carry-out or the SUB borrow.
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] next_result;
    logic             next_carry;
    logic             next_overflow;

    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case can leave it unassigned and infer a latch.
        next_result   = '0;
        next_carry    = 1'b0;
        next_overflow = 1'b0;

        sum_ext  = {1'b0, op1} + {1'b0, op2};
        diff_ext = {1'b0, op1} - {1'b0, op2};

        case (operation)
            ALU_ADD: begin
                next_result   = sum_ext[WIDTH-1:0];
                next_carry    = sum_ext[WIDTH];
                // Same-sign operands giving a different-sign sum.
                next_overflow = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                                (sum_ext[WIDTH-1] != op1[WIDTH-1]);
            end
            ALU_SUB: begin
                next_result   = diff_ext[WIDTH-1:0];
                // The wrapped top bit of the widened difference is the borrow,
                // which is set exactly when A < B unsigned.
                next_carry    = diff_ext[WIDTH];
                next_overflow = (op1[WIDTH-1] != op2[WIDTH-1]) &&
                                (diff_ext[WIDTH-1] != op1[WIDTH-1]);
            end
            ALU_AND: next_result = op1 & op2;
            ALU_OR:  next_result = op1 | op2;
            ALU_XOR: next_result = op1 ^ op2;
            ALU_LT:  next_result = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            // Unused encodings 6 and 7 keep the all-zero defaults.
            default: ;
        endcase
    end

    // Every flag is registered from the same next-state value as the result,
    // so zero and negative always agree with the result they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result   <= '0;
            zero     <= 1'b1;
            carry    <= 1'b0;
            overflow <= 1'b0;
            negative <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make all registers update
            // together from values sampled before the edge.
            result   <= next_result;
            zero     <= (next_result == '0);
            carry    <= next_carry;
            overflow <= next_overflow;
            negative <= next_result[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_alu.sv
// ----------------------------------------------------------------------------
// tb_alu -- self-checking bench for alu (WIDTH = 4).
//
// Directed cases use hand-worked expected values. Random cases are compared
// against an integer-arithmetic reference model. The reset cases exercise
// asynchronous assertion between edges and the first edge after release.
// ----------------------------------------------------------------------------

module tb_alu;
    import custom_types::*;

    localparam int W = 4;

    logic           clk;
    logic           reset;
    logic [W-1:0]   op1;
    logic [W-1:0]   op2;
    alu_operation_t operation;
    logic [W-1:0]   result;
    logic           zero;
    logic           carry;
    logic           overflow;
    logic           negative;

    int checks;
    int errors;

    alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .op1       (op1),
        .op2       (op2),
        .operation (operation),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .negative  (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {result, zero, carry, overflow, negative}.
    function automatic logic [W+3:0] observed();
        return {result, zero, carry, overflow, negative};
    endfunction

    // Reference model in plain integer arithmetic: the result is taken mod
    // 2^W, and signed overflow means the true signed result leaves the
    // representable range.
    function automatic logic [W+3:0] model(input int op, input int a, input int b);
        int m;
        int half;
        int sa;
        int sb;
        int r;
        int c;
        int v;
        logic [31:0] rv;
        m    = 1 << W;
        half = m / 2;
        sa   = (a >= half) ? a - m : a;
        sb   = (b >= half) ? b - m : b;
        r    = 0;
        c    = 0;
        v    = 0;
        case (op)
            0: begin
                r = (a + b) % m;
                c = (a + b >= m) ? 1 : 0;
                v = (sa + sb > half - 1 || sa + sb < -half) ? 1 : 0;
            end
            1: begin
                r = (a - b + m) % m;
                c = (a < b) ? 1 : 0;
                v = (sa - sb > half - 1 || sa - sb < -half) ? 1 : 0;
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = (a < b) ? 1 : 0;
            default: r = 0;
        endcase
        rv = r;
        return {rv[W-1:0], (r == 0), c[0], v[0], (r >= half)};
    endfunction

    // Drive inputs on the falling edge, then wait until just after the next
    // rising edge so the registered response can be sampled.
    task automatic drive(input int op, input int a, input int b);
        logic [2:0] opv;
        @(negedge clk);
        opv       = op[2:0];
        operation = alu_operation_t'(opv);
        op1       = a[W-1:0];
        op2       = b[W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op1 = 4'd5; op2 = 4'd5; operation = ALU_ADD;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (observed() !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got %b want %b", observed(),
                     {4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        reset = 1'b0;
        // REQ-031: first edge after release registers the current inputs.
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== {4'd10, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL reset_first_edge: got %b want %b", observed(),
                     {4'd10, 1'b0, 1'b0, 1'b1, 1'b1});
        end
    endtask

    typedef struct {
        int          op;
        int          a;
        int          b;
        logic [W+3:0] exp;
        string       name;
    } vec_t;

    task automatic test_directed();
        vec_t v[$];
        v.push_back('{0,  5,  5, {4'd10, 1'b0, 1'b0, 1'b1, 1'b1}, "add_5_5"});
        v.push_back('{0, 15,  1, {4'd0,  1'b1, 1'b1, 1'b0, 1'b0}, "add_15_1"});
        v.push_back('{1, 10,  5, {4'd5,  1'b0, 1'b0, 1'b1, 1'b0}, "sub_10_5"});
        v.push_back('{1, 10, 10, {4'd0,  1'b1, 1'b0, 1'b0, 1'b0}, "sub_10_10"});
        v.push_back('{1,  5, 10, {4'd11, 1'b0, 1'b1, 1'b1, 1'b1}, "sub_5_10"});
        v.push_back('{2, 15, 12, {4'd12, 1'b0, 1'b0, 1'b0, 1'b1}, "and"});
        v.push_back('{3, 10,  5, {4'd15, 1'b0, 1'b0, 1'b0, 1'b1}, "or"});
        v.push_back('{4, 15, 10, {4'd5,  1'b0, 1'b0, 1'b0, 1'b0}, "xor"});
        v.push_back('{5,  5, 10, {4'd1,  1'b0, 1'b0, 1'b0, 1'b0}, "lt_true"});
        v.push_back('{5, 10,  5, {4'd0,  1'b1, 1'b0, 1'b0, 1'b0}, "lt_false"});
        v.push_back('{7, 15, 15, {4'd0,  1'b1, 1'b0, 1'b0, 1'b0}, "enc7"});
        v.push_back('{6, 15,  1, {4'd0,  1'b1, 1'b0, 1'b0, 1'b0}, "enc6"});
        foreach (v[i]) begin
            drive(v[i].op, v[i].a, v[i].b);
            checks++;
            if (observed() !== v[i].exp) begin
                errors++;
                $display("FAIL %s: got %b want %b", v[i].name, observed(), v[i].exp);
            end
        end
    endtask

    // Back-to-back random operations, one per cycle, including encodings 6/7.
    task automatic test_random();
        int op;
        int a;
        int b;
        logic [W+3:0] exp;
        for (int i = 0; i < 300; i++) begin
            op  = int'($urandom_range(0, 7));
            a   = int'($urandom_range(0, (1 << W) - 1));
            b   = int'($urandom_range(0, (1 << W) - 1));
            exp = model(op, a, b);
            drive(op, a, b);
            checks++;
            if (observed() !== exp) begin
                errors++;
                $display("FAIL random op=%0d a=%0d b=%0d: got %b want %b",
                         op, a, b, observed(), exp);
            end
        end
    endtask

    // Reset asserted between edges while result = 10 must clear the outputs
    // at once and hold them until the first edge after release.
    task automatic test_async_reset();
        drive(0, 5, 5);
        checks++;
        if (result !== 4'd10) begin
            errors++;
            $display("FAIL pre_reset_result: got %0d want 10", result);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (observed() !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset_immediate: got %b want %b", observed(),
                     {4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        op1 = 4'd15; op2 = 4'd1; operation = ALU_ADD;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (observed() !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_hold: got %b want %b", observed(),
                     {4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        @(negedge clk);
        op1 = 4'd5; op2 = 4'd10; operation = ALU_SUB;
        reset = 1'b0;
        #1;
        checks++;
        if (observed() !== {4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_release_hold: got %b want %b", observed(),
                     {4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        end
        @(posedge clk);
        #1;
        checks++;
        if (observed() !== {4'd11, 1'b0, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL post_release_sub: got %b want %b", observed(),
                     {4'd11, 1'b0, 1'b1, 1'b1, 1'b1});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_random();
        test_async_reset();
        test_directed();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu.md
ALU -- requirements
Module: alu

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 op1  input  WIDTH  first operand (A).
REQ-005 op2  input  WIDTH  second operand (B).
REQ-006 operation  input  alu_operation_t  operation select, from package custom_types.
REQ-007 result  output  WIDTH  registered operation result.
REQ-008 zero  output  1  registered; high when result is all zeros.
REQ-009 carry  output  1  registered; ADD carry-out, or SUB borrow (A < B unsigned).
REQ-010 overflow  output  1  registered; two's-complement signed overflow of ADD/SUB.
REQ-011 negative  output  1  registered; copy of result MSB.

Function
REQ-012 The alu_operation_t encoding SHALL be: ALU_ADD=0, ALU_SUB=1, ALU_AND=2, ALU_OR=3, ALU_XOR=4, ALU_LT=5; the enum SHALL be 3 bits wide.
REQ-013 ALU_ADD SHALL compute (A + B) mod 2^WIDTH.
REQ-014 ALU_SUB SHALL compute (A - B) mod 2^WIDTH.
REQ-015 ALU_AND, ALU_OR and ALU_XOR SHALL compute the bitwise AND, OR and XOR of A and B.
REQ-016 ALU_LT SHALL be an unsigned compare: result = 1 (LSB set, upper bits 0) when A < B, else 0.
REQ-017 Encodings 6 and 7 SHALL produce result = 0, carry = 0 and overflow = 0.
REQ-018 All outputs SHALL be registered with one-cycle latency: inputs sampled at rising edge N appear on the outputs after edge N; there is no combinational input-to-output path.
REQ-019 Inputs SHALL be sampled every cycle; there is no handshake, and outputs update on every edge outside reset.
REQ-020 zero SHALL be derived from the registered result value, so zero and result are always mutually consistent.
REQ-021 carry SHALL equal bit WIDTH of the (WIDTH+1)-bit unsigned sum for ADD.
REQ-022 carry SHALL be 1 for SUB exactly when A < B unsigned.
REQ-023 carry SHALL be 0 for logic and LT operations.
REQ-024 overflow SHALL be 1 for ADD when A and B have the same sign and the result sign differs.
REQ-025 overflow SHALL be 1 for SUB when A and B have different signs and the result sign differs from A.
REQ-026 overflow SHALL be 0 for all other operations.
REQ-027 negative SHALL equal result[WIDTH-1] for every operation.
REQ-028 No X or Z SHALL appear on any output after reset, provided the inputs are known.

Reset
REQ-029 While reset is high, result = 0, zero = 1, carry = 0, overflow = 0 and negative = 0, taking effect immediately without waiting for a clock edge.
REQ-030 Reset asserted mid-operation SHALL discard the pending result.
REQ-031 The first edge after reset deasserts SHALL register the current inputs normally.

Verification (WIDTH=4; each response is checked one clock after the stimulus)
REQ-032 ADD: 5 + 5 -> result 10, zero 0, carry 0, overflow 1, negative 1; ADD 15 + 1 -> result 0, zero 1, carry 1, overflow 0.
REQ-033 SUB: 10 - 5 -> result 5, carry 0; SUB 10 - 10 -> result 0, zero 1; SUB 5 - 10 -> result 11, carry 1.
REQ-034 Logic: AND 1111 & 1100 -> 1100; OR 1010 | 0101 -> 1111; XOR 1111 ^ 1010 -> 0101; each with carry 0 and overflow 0.
REQ-035 LT: 5 < 10 -> result 1, zero 0; LT 10 < 5 -> result 0, zero 1; encoding 7 -> result 0, zero 1.
REQ-036 Reset: assert reset asynchronously between edges while result = 10 -> all outputs take reset values immediately and hold them until the first edge after deassertion.
